// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits,
// 16x oversampled receiver and double-buffered transmitter.
module uart_core_param #(
    parameter int clk_freq  = 50000000,
    parameter int baud      = 115200,
    parameter int data_bits = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_tx_data,
    input  logic [data_bits-1:0] tx_data,
    input  logic                 tx_enable,
    output logic                 tx_out,
    output logic                 tx_empty,
    output logic                 tx_busy,
    input  logic                 uld_rx_data,
    output logic [data_bits-1:0] rx_data,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int div_raw = clk_freq / (baud * 16);
    localparam int div     = (div_raw < 1) ? 1 : div_raw;
    localparam int cnt_w   = (div > 1) ? $clog2(div) : 1;

    localparam logic [cnt_w-1:0] cnt_max   = cnt_w'(div - 1);
    localparam logic [3:0]       last_bit  = 4'(data_bits - 1);
    localparam logic             stop_last = 1'(stop_bits - 1);
    localparam logic             par_odd   = (parity == 1);
    localparam logic             par_on    = (parity != 0);

    typedef enum logic [2:0] {
        s_idle,
        s_start,
        s_data,
        s_parity,
        s_stop,
        s_break
    } state_t;

    // tick generator
    logic [cnt_w-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == cnt_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // transmitter
    state_t               tx_state;
    logic [data_bits-1:0] tx_hold;
    logic [data_bits-1:0] tx_shift;
    logic                 tx_par;
    logic [3:0]           tx_ph;
    logic [3:0]           tx_bit;
    logic                 tx_stop;
    logic                 tx_go;

    assign tx_go = tx_enable && !tx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= s_idle;
            tx_hold  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_ph    <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_out   <= 1'b1;
            tx_empty <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            if (ld_tx_data && tx_empty) begin
                tx_hold  <= tx_data;
                tx_empty <= 1'b0;
            end
            if (tick) begin
                tx_ph <= (tx_state == s_idle) ? 4'd0 : tx_ph + 4'd1;
                unique case (tx_state)
                    s_idle: begin
                        if (tx_go) begin
                            tx_shift <= tx_hold;
                            tx_par   <= (^tx_hold) ^ par_odd;
                            tx_empty <= 1'b1;
                            tx_busy  <= 1'b1;
                            tx_out   <= 1'b0;
                            tx_state <= s_start;
                        end
                    end
                    s_start: begin
                        if (tx_ph == 4'd15) begin
                            tx_out   <= tx_shift[0];
                            tx_bit   <= '0;
                            tx_state <= s_data;
                        end
                    end
                    s_data: begin
                        if (tx_ph == 4'd15) begin
                            if (tx_bit == last_bit) begin
                                tx_stop <= 1'b0;
                                if (par_on) begin
                                    tx_out   <= tx_par;
                                    tx_state <= s_parity;
                                end else begin
                                    tx_out   <= 1'b1;
                                    tx_state <= s_stop;
                                end
                            end else begin
                                tx_bit   <= tx_bit + 4'd1;
                                tx_shift <= tx_shift >> 1;
                                tx_out   <= tx_shift[1];
                            end
                        end
                    end
                    s_parity: begin
                        if (tx_ph == 4'd15) begin
                            tx_out   <= 1'b1;
                            tx_stop  <= 1'b0;
                            tx_state <= s_stop;
                        end
                    end
                    s_stop: begin
                        if (tx_ph == 4'd15) begin
                            if (tx_stop != stop_last) begin
                                tx_stop <= 1'b1;
                            end else if (tx_go) begin
                                // back-to-back frame, no idle bit
                                tx_shift <= tx_hold;
                                tx_par   <= (^tx_hold) ^ par_odd;
                                tx_empty <= 1'b1;
                                tx_out   <= 1'b0;
                                tx_state <= s_start;
                            end else begin
                                tx_busy  <= 1'b0;
                                tx_state <= s_idle;
                            end
                        end
                    end
                    default: begin
                        tx_state <= s_idle;
                    end
                endcase
            end
        end
    end

    // receiver
    state_t               rx_state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic [data_bits-1:0] rx_shift;
    logic [3:0]           rx_ph;
    logic [3:0]           rx_bit;
    logic                 rx_stop;
    logic                 rx_fe_acc;
    logic                 rx_pe_acc;
    logic                 rx_par_exp;
    logic                 rx_fe_new;

    assign rx_par_exp = (^rx_shift) ^ par_odd;
    assign rx_fe_new  = rx_fe_acc | !rx_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state      <= s_idle;
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_shift      <= '0;
            rx_ph         <= '0;
            rx_bit        <= '0;
            rx_stop       <= 1'b0;
            rx_fe_acc     <= 1'b0;
            rx_pe_acc     <= 1'b0;
            rx_data       <= '0;
            rx_empty      <= 1'b1;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            if (uld_rx_data && !rx_empty) begin
                rx_empty      <= 1'b1;
                rx_frame_err  <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_overrun    <= 1'b0;
            end
            if (!rx_enable) begin
                rx_state <= s_idle;
            end else begin
                unique case (rx_state)
                    s_idle: begin
                        if (!rx_s2) begin
                            rx_ph    <= '0;
                            rx_state <= s_start;
                        end
                    end
                    s_start: begin
                        if (tick) begin
                            if (rx_ph == 4'd8) begin
                                if (rx_s2) begin
                                    rx_state <= s_idle;
                                end else begin
                                    rx_ph     <= '0;
                                    rx_bit    <= '0;
                                    rx_fe_acc <= 1'b0;
                                    rx_pe_acc <= 1'b0;
                                    rx_state  <= s_data;
                                end
                            end else begin
                                rx_ph <= rx_ph + 4'd1;
                            end
                        end
                    end
                    s_data: begin
                        if (tick) begin
                            rx_ph <= rx_ph + 4'd1;
                            if (rx_ph == 4'd15) begin
                                rx_shift <= {rx_s2, rx_shift[data_bits-1:1]};
                                rx_bit   <= rx_bit + 4'd1;
                                if (rx_bit == last_bit) begin
                                    rx_stop  <= 1'b0;
                                    rx_state <= par_on ? s_parity : s_stop;
                                end
                            end
                        end
                    end
                    s_parity: begin
                        if (tick) begin
                            rx_ph <= rx_ph + 4'd1;
                            if (rx_ph == 4'd15) begin
                                rx_pe_acc <= (rx_s2 != rx_par_exp);
                                rx_stop   <= 1'b0;
                                rx_state  <= s_stop;
                            end
                        end
                    end
                    s_stop: begin
                        if (tick) begin
                            rx_ph <= rx_ph + 4'd1;
                            if (rx_ph == 4'd15) begin
                                if (rx_stop != stop_last) begin
                                    rx_stop   <= 1'b1;
                                    rx_fe_acc <= rx_fe_new;
                                end else begin
                                    if (rx_empty || uld_rx_data) begin
                                        rx_data       <= rx_shift;
                                        rx_empty      <= 1'b0;
                                        rx_frame_err  <= rx_fe_new;
                                        rx_parity_err <= rx_pe_acc;
                                        rx_overrun    <= 1'b0;
                                    end else begin
                                        rx_overrun    <= 1'b1;
                                        rx_frame_err  <= rx_frame_err | rx_fe_new;
                                        rx_parity_err <= rx_parity_err | rx_pe_acc;
                                    end
                                    // a held-low line is a break: wait for idle
                                    rx_state <= rx_s2 ? s_idle : s_break;
                                end
                            end
                        end
                    end
                    s_break: begin
                        if (rx_s2) begin
                            rx_state <= s_idle;
                        end
                    end
                    default: begin
                        rx_state <= s_idle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Randomised bench for uart_core_param: three configurations checked
// against a frame-level reference model.
module tb_uart_core_param;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    // instance a: 8N1, instance b: 7E2 loopback, instance c: 8O1
    logic       ld_a = 0, en_a = 1, uld_a = 0, rxen_a = 1, rx_in_a = 1;
    logic [7:0] txd_a = 0;
    logic [7:0] rxd_a;
    logic       tx_out_a, tx_empty_a, tx_busy_a;
    logic       rx_empty_a, fe_a, pe_a, ov_a;

    logic       ld_b = 0, en_b = 1, uld_b = 0, rxen_b = 1;
    logic [6:0] txd_b = 0;
    logic [6:0] rxd_b;
    logic       tx_out_b, tx_empty_b, tx_busy_b;
    logic       rx_empty_b, fe_b, pe_b, ov_b;

    logic       ld_c = 0, en_c = 1, uld_c = 0, rxen_c = 1, rx_in_c = 1;
    logic [7:0] txd_c = 0;
    logic [7:0] rxd_c;
    logic       tx_out_c, tx_empty_c, tx_busy_c;
    logic       rx_empty_c, fe_c, pe_c, ov_c;

    uart_core_param #(
        .clk_freq(16000000), .baud(1000000),
        .data_bits(8), .parity(0), .stop_bits(1)
    ) u_a (
        .clk(clk), .reset(reset),
        .ld_tx_data(ld_a), .tx_data(txd_a), .tx_enable(en_a),
        .tx_out(tx_out_a), .tx_empty(tx_empty_a), .tx_busy(tx_busy_a),
        .uld_rx_data(uld_a), .rx_data(rxd_a), .rx_enable(rxen_a),
        .rx_in(rx_in_a), .rx_empty(rx_empty_a),
        .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a)
    );

    uart_core_param #(
        .clk_freq(16000000), .baud(1000000),
        .data_bits(7), .parity(2), .stop_bits(2)
    ) u_b (
        .clk(clk), .reset(reset),
        .ld_tx_data(ld_b), .tx_data(txd_b), .tx_enable(en_b),
        .tx_out(tx_out_b), .tx_empty(tx_empty_b), .tx_busy(tx_busy_b),
        .uld_rx_data(uld_b), .rx_data(rxd_b), .rx_enable(rxen_b),
        .rx_in(tx_out_b), .rx_empty(rx_empty_b),
        .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b)
    );

    uart_core_param #(
        .clk_freq(16000000), .baud(1000000),
        .data_bits(8), .parity(1), .stop_bits(1)
    ) u_c (
        .clk(clk), .reset(reset),
        .ld_tx_data(ld_c), .tx_data(txd_c), .tx_enable(en_c),
        .tx_out(tx_out_c), .tx_empty(tx_empty_c), .tx_busy(tx_busy_c),
        .uld_rx_data(uld_c), .rx_data(rxd_c), .rx_enable(rxen_c),
        .rx_in(rx_in_c), .rx_empty(rx_empty_c),
        .rx_frame_err(fe_c), .rx_parity_err(pe_c), .rx_overrun(ov_c)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // line image of one frame, bit 0 first; unused upper bits idle high
    function automatic logic [31:0] frame_of(input int data, input int nb,
                                             input int par, input int ns);
        logic [31:0] f;
        logic        p;
        f = '1;
        f[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[1+i] = data[i];
            p = p ^ data[i];
        end
        if (par != 0) f[1+nb] = (par == 2) ? p : !p;
        return f;
    endfunction

    function automatic int len_of(input int nb, input int par, input int ns);
        return 1 + nb + ((par != 0) ? 1 : 0) + ns;
    endfunction

    function automatic logic tx_line(input int k);
        case (k)
            0: return tx_out_a;
            1: return tx_out_b;
            default: return tx_out_c;
        endcase
    endfunction

    function automatic logic [1:0] tx_st(input int k);
        case (k)
            0: return {tx_empty_a, tx_busy_a};
            1: return {tx_empty_b, tx_busy_b};
            default: return {tx_empty_c, tx_busy_c};
        endcase
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_tx(input int k, input logic [31:0] exp,
                            input int len, input string tag,
                            output int lat, output logic [1:0] st);
        logic [31:0] got;
        int n;
        got = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_line(k) !== 1'b0 && n < 400);
        lat = n;
        st = tx_st(k);
        if (tx_line(k) !== 1'b0) begin
            check({tag, "_start"}, 32'(tx_line(k)), 0);
            return;
        end
        repeat (8) @(negedge clk);
        got[0] = tx_line(k);
        for (int j = 1; j < len; j++) begin
            repeat (16) @(negedge clk);
            got[j] = tx_line(k);
        end
        check(tag, got, exp);
    endtask

    task automatic set_rx(input int k, input logic b);
        if (k == 0) rx_in_a = b;
        else rx_in_c = b;
    endtask

    // 16 clk per bit; optional unload pulse on the completion cycle of a
    task automatic drive_rx(input int k, input logic [31:0] f,
                            input int len, input bit uld_late);
        for (int j = 0; j < len; j++) begin
            set_rx(k, f[j]);
            if (uld_late && j == len - 1) begin
                tick_n(11);
                uld_a = 1;
                tick_n(1);
                uld_a = 0;
                tick_n(4);
            end else begin
                tick_n(16);
            end
        end
        set_rx(k, 1'b1);
        tick_n(4);
    endtask

    task automatic unload_a();
        uld_a = 1;
        tick_n(1);
        uld_a = 0;
    endtask

    initial begin
        int lat;
        logic [1:0] st;
        int d;
        logic [31:0] f;

        tick_n(3);
        reset = 0;
        tick_n(1);
        check("rst_tx_out", tx_out_a, 1);
        check("rst_tx_st", {tx_empty_a, tx_busy_a}, 2'b10);
        check("rst_rx_data", rxd_a, 0);
        check("rst_rx_empty", rx_empty_a, 1);
        check("rst_flags", {fe_a, pe_a, ov_a}, 0);

        // baseline 0xA5
        ld_a = 1;
        txd_a = 8'hA5;
        tick_n(1);
        ld_a = 0;
        check("ld_full", tx_empty_a, 0);
        check_tx(0, frame_of(8'hA5, 8, 0, 1), 10, "tx_a5", lat, st);
        check("tx_a5_lat", 32'(lat <= 2), 1);
        check("tx_a5_st", st, 2'b11);
        tick_n(10);
        check("tx_a5_idle", {tx_busy_a, tx_out_a}, 2'b01);

        // load while full is ignored
        en_a = 0;
        ld_a = 1;
        txd_a = 8'h0F;
        tick_n(1);
        check("hold_full", tx_empty_a, 0);
        txd_a = 8'hF0;
        tick_n(1);
        ld_a = 0;
        en_a = 1;
        check_tx(0, frame_of(8'h0F, 8, 0, 1), 10, "tx_hold", lat, st);

        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            d = $urandom_range(0, 255);
            ld_a = 1;
            txd_a = 8'(d);
            tick_n(1);
            ld_a = 0;
            check_tx(0, frame_of(d, 8, 0, 1), 10, "tx_rand", lat, st);
        end
        tick_n(30);

        // glitch rejection
        set_rx(0, 1'b0);
        tick_n(6);
        set_rx(0, 1'b1);
        tick_n(40);
        check("glitch_empty", rx_empty_a, 1);

        // frame error
        f = frame_of(8'h81, 8, 0, 1);
        f[9] = 1'b0;
        drive_rx(0, f, 10, 0);
        check("fe_data", rxd_a, 8'h81);
        check("fe_flags", {rx_empty_a, fe_a, pe_a, ov_a}, 4'b0100);
        unload_a();
        check("fe_unload", {rx_empty_a, fe_a, pe_a, ov_a}, 4'b1000);

        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 255);
            drive_rx(0, frame_of(d, 8, 0, 1), 10, 0);
            check("rx_rand_data", rxd_a, 32'(d));
            check("rx_rand_flags", {rx_empty_a, fe_a, pe_a, ov_a}, 0);
            unload_a();
            check("rx_rand_unld", rx_empty_a, 1);
        end

        // overrun
        drive_rx(0, frame_of(8'h11, 8, 0, 1), 10, 0);
        drive_rx(0, frame_of(8'h22, 8, 0, 1), 10, 0);
        check("ov_data", rxd_a, 8'h11);
        check("ov_flags", {rx_empty_a, fe_a, pe_a, ov_a}, 4'b0001);
        unload_a();
        check("ov_unload", {rx_empty_a, ov_a}, 2'b10);

        // unload coinciding with completion
        drive_rx(0, frame_of(8'h44, 8, 0, 1), 10, 0);
        drive_rx(0, frame_of(8'h33, 8, 0, 1), 10, 1);
        check("sim_data", rxd_a, 8'h33);
        check("sim_flags", {rx_empty_a, fe_a, pe_a, ov_a}, 0);
        unload_a();

        // loopback 7E2 back-to-back
        ld_b = 1;
        txd_b = 7'h5A;
        tick_n(1);
        ld_b = 0;
        fork
            begin
                int lat2;
                logic [1:0] st2;
                logic [31:0] e1, e2;
                e1 = frame_of(7'h5A, 7, 2, 2);
                e2 = frame_of(7'h3C, 7, 2, 2);
                check_tx(1, (e2 << 11) | (e1 & 32'h7FF), 22, "lb_line",
                         lat2, st2);
            end
            begin
                int n;
                n = 0;
                while (tx_empty_b !== 1'b1 && n < 100) begin
                    tick_n(1);
                    n++;
                end
                check("lb_empty", tx_empty_b, 1);
                ld_b = 1;
                txd_b = 7'h3C;
                tick_n(1);
                ld_b = 0;
                n = 0;
                while (rx_empty_b !== 1'b0 && n < 800) begin
                    tick_n(1);
                    n++;
                end
                check("lb_rx1_data", rxd_b, 7'h5A);
                check("lb_rx1_flags", {rx_empty_b, fe_b, pe_b, ov_b}, 0);
                uld_b = 1;
                tick_n(1);
                uld_b = 0;
                n = 0;
                while (rx_empty_b !== 1'b0 && n < 800) begin
                    tick_n(1);
                    n++;
                end
                check("lb_rx2_data", rxd_b, 7'h3C);
                check("lb_rx2_flags", {rx_empty_b, fe_b, pe_b, ov_b}, 0);
            end
        join
        tick_n(40);

        // odd parity
        d = $urandom_range(0, 255);
        ld_c = 1;
        txd_c = 8'(d);
        tick_n(1);
        ld_c = 0;
        check_tx(2, frame_of(d, 8, 1, 1), 11, "c_tx", lat, st);
        tick_n(20);
        d = $urandom_range(0, 255);
        drive_rx(2, frame_of(d, 8, 1, 1), 11, 0);
        check("c_rx_data", rxd_c, 32'(d));
        check("c_rx_flags", {rx_empty_c, fe_c, pe_c, ov_c}, 0);
        uld_c = 1;
        tick_n(1);
        uld_c = 0;
        f = frame_of(8'h03, 8, 1, 1);
        f[9] = 1'b0;
        drive_rx(2, f, 11, 0);
        check("pe_data", rxd_c, 8'h03);
        check("pe_flags", {rx_empty_c, fe_c, pe_c, ov_c}, 4'b0010);

        // reset mid-frame on both directions
        drive_rx(0, frame_of(8'h5C, 8, 0, 1), 10, 0);
        ld_a = 1;
        txd_a = 8'h77;
        tick_n(1);
        ld_a = 0;
        tick_n(30);
        set_rx(0, 1'b0);
        tick_n(24);
        reset = 1;
        tick_n(1);
        check("mid_rst_tx", {tx_out_a, tx_busy_a, tx_empty_a}, 3'b101);
        check("mid_rst_rx", {rx_empty_a, fe_a, pe_a, ov_a}, 4'b1000);
        check("mid_rst_data", rxd_a, 0);
        set_rx(0, 1'b1);
        reset = 0;
        tick_n(4);
        d = $urandom_range(0, 255);
        drive_rx(0, frame_of(d, 8, 0, 1), 10, 0);
        check("post_rst_rx", {rx_empty_a, rxd_a}, 32'(d));
        d = $urandom_range(0, 255);
        ld_a = 1;
        txd_a = 8'(d);
        tick_n(1);
        ld_a = 0;
        check_tx(0, frame_of(d, 8, 0, 1), 10, "post_rst_tx", lat, st);
        tick_n(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
